fdiv_iter: RTL and testbench
============================

Name: fdiv_iter

Overview:
- Multi-cycle single-precision floating-point divider, d = x / y, for the FPU next to the combinational reciprocal unit.
- Computes the quotient mantissa by restoring division, one bit per cycle, then rounds to nearest-even.
- Uses the same ulp/guard/round/sticky rule as the reciprocal unit.
- Valid/ready handshake on input and output, so the core can issue and stall independently of latency.

Parameters:
QBITS, 27, quotient bits generated: 1 integer, 23 fraction, guard, round, plus 1 spare; fixed, not for tuning.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
s_valid  input  1  operands x, y are valid
s_ready  output  1  unit can accept operands (IDLE only)
x  input  32  dividend, IEEE-754 single
y  input  32  divisor, IEEE-754 single
d_valid  output  1  result valid
d_ready  input  1  consumer accepts result
d  output  32  quotient
overflow  output  1  result saturated to infinity (incl. divide by zero); valid with d_valid
underflow  output  1  result flushed to zero; valid with d_valid

Behaviour:
- Reset (async, any state): state=IDLE; s_ready=1; d_valid=0; d=0; overflow=0; underflow=0; all internal registers cleared. An in-flight division is discarded and no result is produced.
- States: IDLE, DIV, ROUND, DONE.
- IDLE, s_valid=1: accept on that edge and latch:
  - sign = x[31]^y[31];
  - e = {2'b0,x[30:23]} - {2'b0,y[30:23]} + 127, 10-bit signed;
  - remainder r = {1,x[22:0]}, 25 bits; divisor m = {1,y[22:0]}.
- Special cases at accept (exponent 0 = zero, denormals flushed; no NaN/Inf-input handling):
  - x exp = 0 and y exp != 0: result {sign,31'b0}, go to DONE.
  - y exp = 0: result {sign,8'hFF,23'b0}, overflow=1, go to DONE (0/0 included).
  - Otherwise go to DIV with counter = 0.
- DIV, one cycle per bit, QBITS cycles:
  - if r >= m then qbit=1, r = r - m, else qbit=0;
  - r = r << 1; q = {q[25:0], qbit}; counter++;
  - leave to ROUND when counter = QBITS-1.
- ROUND, one cycle:
  - q[26]=1: mant = q[25:3], g = q[2], rb = q[1], s = q[0] | (r != 0).
  - q[26]=0: e = e - 1, mant = q[24:2], g = q[1], rb = q[0], s = (r != 0).
  - inc = g & (rb | s | mant[0]).
  - mant + inc, 24-bit; on carry-out mant = 0 and e = e + 1.
  - e >= 255: d = {sign,8'hFF,0}, overflow=1.
  - e <= 0: d = {sign,31'b0}, underflow=1.
  - else d = {sign,e[7:0],mant}.
  - Go to DONE.
- DONE: d_valid=1; d, overflow and underflow held stable.
  - On d_valid & d_ready: clear d_valid, overflow and underflow; go to IDLE.
  - s_ready stays 0, so there is no same-cycle re-accept.
- Latency from accept edge to d_valid=1:
  - normal operands: QBITS+1 = 28 cycles;
  - special cases: 1 cycle.
- Throughput: one operation in flight. s_ready = (state == IDLE), registered.
- x, y are don't-care outside the accept cycle.

Decomposition:
- fpu_pkg holds:
  - EXP_W=8, MANT_W=23, EXP_BIAS=127;
  - FP_POS_INF=32'h7F800000;
  - state encoding IDLE/DIV/ROUND/DONE.
- One sub-module: fp_round_rne (inputs ulp, guard, round, sticky; output inc), also reusable by the reciprocal and multiply units.

Test Plan:
- x=0x40C00000 (6.0), y=0x40000000 (2.0), d_ready=1 -> d=0x40400000 28 cycles after accept; overflow=0, underflow=0.
- x=0x3F800000, y=0x40400000 (1/3) -> d=0x3EAAAAAB, exercising the round-up path with the sticky bit from the remainder.
- x=0xBF800000, y=0x00000000 -> d=0xFF800000, overflow=1, 1 cycle after accept. x=0x00000000, y=0x40A00000 -> d=0x00000000, overflow=0, underflow=0.
- x=0x7F000000, y=0x3E800000 -> d=0x7F800000, overflow=1. x=0x00800000, y=0x40000000 -> d=0x00000000, underflow=1.
- Backpressure: hold d_ready=0 for 10 cycles in DONE -> d_valid, d and flags stable and s_ready=0. Raise d_ready -> one handshake, then s_ready=1 next cycle. Assert s_valid continuously -> back-to-back operations, each accepted only in IDLE.
- Assert rst at DIV counter=10 -> s_ready=1, d_valid=0 immediately. Next operation 0x41200000 / 0x40A00000 -> 0x40000000 with no residue from the aborted operation.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, constants and the
// iterative divider's state encoding.
package fpu_pkg;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } div_state_e;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment decision from ulp/guard/round/sticky bits,
// shared by the divider, reciprocal and multiply units.
module fp_round_rne (
  input  logic ulp,
  input  logic guard,
  input  logic round,
  input  logic sticky,
  output logic inc
);
  // Exactly half-way (round=sticky=0) only rounds up when that makes the ulp even.
  assign inc = guard & (round | sticky | ulp);
endmodule

// File: rtl/fdiv_iter.sv
// Multi-cycle single-precision divider d = x / y: restoring division one
// quotient bit per cycle, then a single round-to-nearest-even step.
module fdiv_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow
);
  localparam int QBITS = 27;

  div_state_e         r_state;
  div_state_e         w_state_next;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [24:0]        r_rem;
  logic [MANT_W:0]    r_div;
  logic [QBITS-1:0]   r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_d;
  logic               r_ovf;
  logic               r_unf;
  logic               r_dvalid;
  logic               r_sready;

  logic               w_sign;
  logic               w_x_zero;
  logic               w_y_zero;
  logic signed [9:0]  w_exp_init;
  logic               w_ge;
  logic [24:0]        w_rem_sub;
  logic [24:0]        w_rem_next;
  logic               w_norm;
  logic [22:0]        w_mant;
  logic               w_g;
  logic               w_rb;
  logic               w_s;
  logic               w_inc;
  logic signed [9:0]  w_exp_adj;
  logic [23:0]        w_mant_inc;
  logic signed [9:0]  w_exp_rnd;
  logic               w_ovf;
  logic               w_unf;

  assign w_sign     = x[31] ^ y[31];
  assign w_x_zero   = (x[MANT_W +: EXP_W] == '0);
  assign w_y_zero   = (y[MANT_W +: EXP_W] == '0);
  assign w_exp_init = $signed({2'b00, x[MANT_W +: EXP_W]})
                    - $signed({2'b00, y[MANT_W +: EXP_W]})
                    + 10'(EXP_BIAS);

  // Remainder stays below twice the divisor, so the shifted-out MSB is always zero.
  assign w_ge       = (r_rem >= {1'b0, r_div});
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  assign w_rem_next = {w_rem_sub[23:0], 1'b0};

  assign w_norm    = r_q[QBITS-1];
  assign w_mant    = w_norm ? r_q[25:3] : r_q[24:2];
  assign w_g       = w_norm ? r_q[2] : r_q[1];
  assign w_rb      = w_norm ? r_q[1] : r_q[0];
  assign w_s       = (w_norm & r_q[0]) | (r_rem != '0);
  assign w_exp_adj = w_norm ? r_exp : (r_exp - 10'sd1);

  fp_round_rne u_round (
    .ulp    (w_mant[0]),
    .guard  (w_g),
    .round  (w_rb),
    .sticky (w_s),
    .inc    (w_inc)
  );

  // A carry out of the mantissa leaves the fraction bits all zero.
  assign w_mant_inc = {1'b0, w_mant} + {23'b0, w_inc};
  assign w_exp_rnd  = w_mant_inc[23] ? (w_exp_adj + 10'sd1) : w_exp_adj;
  assign w_ovf      = (w_exp_rnd >= 10'sd255);
  assign w_unf      = (w_exp_rnd <= 10'sd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (s_valid) w_state_next = (w_x_zero || w_y_zero) ? DONE : DIV;
      DIV:     if (r_cnt == 5'(QBITS-1)) w_state_next = ROUND;
      ROUND:   w_state_next = DONE;
      DONE:    if (d_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_dvalid <= 1'b0;
      r_sready <= 1'b1;
    end else begin
      r_sready <= (w_state_next == IDLE);
      case (r_state)
        IDLE: if (s_valid) begin
          r_sign <= w_sign;
          r_exp  <= w_exp_init;
          r_rem  <= {2'b01, x[MANT_W-1:0]};
          r_div  <= {1'b1, y[MANT_W-1:0]};
          r_q    <= '0;
          r_cnt  <= '0;
          // Zero divisor wins over zero dividend, so 0/0 also saturates.
          if (w_y_zero) begin
            r_d      <= {w_sign, FP_POS_INF[30:0]};
            r_ovf    <= 1'b1;
            r_dvalid <= 1'b1;
          end else if (w_x_zero) begin
            r_d      <= {w_sign, 31'b0};
            r_dvalid <= 1'b1;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        ROUND: begin
          r_dvalid <= 1'b1;
          if (w_ovf) begin
            r_d   <= {r_sign, FP_POS_INF[30:0]};
            r_ovf <= 1'b1;
          end else if (w_unf) begin
            r_d   <= {r_sign, 31'b0};
            r_unf <= 1'b1;
          end else begin
            r_d <= {r_sign, w_exp_rnd[7:0], w_mant_inc[22:0]};
          end
        end
        DONE: if (d_ready) begin
          r_dvalid <= 1'b0;
          r_ovf    <= 1'b0;
          r_unf    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = r_sready;
  assign d_valid   = r_dvalid;
  assign d         = r_d;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: exact-arithmetic reference model plus a
// per-cycle scoreboard, with hand-computed literal results per vector.
module tb_fdiv_iter;
  localparam int QBITS_TB = 27;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        ov;
    logic        uf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t expq[$];
  bit   prevHs = 1'b0;
  bit   firstSeen = 1'b0;

  fdiv_iter dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .x         (x),
    .y         (y),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d         (d),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact quotient of the mantissas scaled by 2^40, rounded to nearest-even.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic            sgn;
    int              e;
    int              sh;
    longint unsigned ma, mb, qq, rm, mant, low, half;
    logic            up;
    sgn = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {1'b1, 1'b0, sgn, 8'hFF, 23'h0};
    if (a[30:23] == 8'd0) return {1'b0, 1'b0, sgn, 31'h0};
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    ma = {40'h0, 1'b1, a[22:0]};
    mb = {40'h0, 1'b1, b[22:0]};
    qq = (ma << 40) / mb;
    rm = (ma << 40) % mb;
    if (qq >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    mant = qq >> sh;
    low  = qq & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    up   = (low > half) || ((low == half) && ((rm != 0) || mant[0]));
    mant = mant + {63'd0, up};
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) return {1'b1, 1'b0, sgn, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b0, 1'b1, sgn, 31'h0};
    return {1'b0, 1'b0, sgn, 8'(e), mant[22:0]};
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard: every sample, outputs against the model's queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [33:0] m;
    cyc++;
    if (rst) begin
      checkValue("reset_state", {d_valid, s_ready, overflow, underflow, 28'h0} ^ d,
                 {4'b0100, 28'h0});
      expq.delete();
      prevHs    = 1'b0;
      firstSeen = 1'b0;
    end else begin
      checkValue("ready_valid_exclusive", {31'h0, s_ready & d_valid}, 32'h0);
      if (prevHs) checkValue("post_handshake", {30'h0, s_ready, d_valid}, 32'h2);
      prevHs = 1'b0;
      if (d_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got d=%h with nothing outstanding", d);
        end else begin
          checkValue("model_d", d, expq[0].d);
          checkValue("model_flags", {30'h0, overflow, underflow}, {30'h0, expq[0].ov, expq[0].uf});
          if (!firstSeen) begin
            checkValue("latency", 32'(cyc - expq[0].acc), 32'(expq[0].lat));
            firstSeen = 1'b1;
          end
          if (d_ready) begin
            void'(expq.pop_front());
            prevHs    = 1'b1;
            firstSeen = 1'b0;
          end
        end
      end
      if (s_valid && s_ready) begin
        m    = model(x, y);
        e.d  = m[31:0];
        e.ov = m[33];
        e.uf = m[32];
        // Samples from acceptance: the accept edge, then QBITS DIV edges and the ROUND edge.
        e.lat = ((x[30:23] == 8'd0) || (y[30:23] == 8'd0)) ? 1 : QBITS_TB + 2;
        e.acc = cyc;
        expq.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int n;
    x       = a;
    y       = b;
    s_valid = 1'b1;
    n       = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 100);
    checks++;
    if (!s_ready) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got s_ready=%b want 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    x       = $urandom;
    y       = $urandom;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] wantD,
                             input logic wantOv, input logic wantUf);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_valid && n < 60);
    if (!d_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got d_valid=0 want 1", name);
    end else begin
      checkValue(name, d, wantD);
      checkValue({name, "_flags"}, {30'h0, overflow, underflow}, {30'h0, wantOv, wantUf});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || !s_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %0d outstanding want 0", name, expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    d_ready = 1'b1;
    x       = 32'h0;
    y       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(32'h40C00000, 32'h40000000);
    checkOutput("six_div_two", 32'h40400000, 1'b0, 1'b0);
    applyStimulus(32'h3F800000, 32'h40400000);
    checkOutput("one_third", 32'h3EAAAAAB, 1'b0, 1'b0);
    applyStimulus(32'hBF800000, 32'h00000000);
    checkOutput("div_by_zero", 32'hFF800000, 1'b1, 1'b0);
    applyStimulus(32'h00000000, 32'h40A00000);
    checkOutput("zero_dividend", 32'h00000000, 1'b0, 1'b0);
    applyStimulus(32'h7F000000, 32'h3E800000);
    checkOutput("overflow", 32'h7F800000, 1'b1, 1'b0);
    applyStimulus(32'h00800000, 32'h40000000);
    checkOutput("underflow", 32'h00000000, 1'b0, 1'b1);
    applyStimulus(32'hC1200000, 32'h40A00000);
    checkOutput("neg_ten_div_five", 32'hC0000000, 1'b0, 1'b0);
    applyStimulus(32'h00000000, 32'h00000000);
    checkOutput("zero_div_zero", 32'h7F800000, 1'b1, 1'b0);

    // Backpressure: result must hold while the consumer stalls.
    d_ready = 1'b0;
    applyStimulus(32'h40C00000, 32'h40000000);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!d_valid && n < 60);
    end
    for (int i = 0; i < 10; i++) begin
      checkValue("stall_hold", {d_valid, s_ready, overflow, underflow, 28'h0} ^ d,
                 {4'b1000, 28'h0} ^ 32'h40400000);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    d_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkValue("stall_release", {30'h0, s_ready, d_valid}, 32'h2);
    @(posedge clk);
    #1;

    // Back-to-back with s_valid held high throughout.
    begin
      logic [31:0] ops [6];
      ops = '{32'h41200000, 32'h40A00000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h40000000};
      s_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        int n;
        x = ops[2*k];
        y = ops[2*k+1];
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!s_ready && n < 100);
        @(posedge clk);
        #1;
      end
      s_valid = 1'b0;
      drain("back_to_back");
    end

    // Reset in the middle of a division, then a clean operation.
    applyStimulus(32'h3F800000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkValue("abort_reset", {30'h0, s_ready, d_valid}, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(32'h41200000, 32'h40A00000);
    checkOutput("after_abort", 32'h40000000, 1'b0, 1'b0);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
